cyq_xs3_tx: RTL



---
 rtl/cyq_xs3_tx.sv | 117 +++++++++++
 1 files changed

// File: rtl/cyq_xs3_tx.sv
// BCD-to-excess-3 serial transmitter: encodes DIGITS BCD digits and shifts the frame out MSB first.
// Define CYQ_XS3_TX_PARITY_EN to append an odd-parity bit after the payload.
module cyq_xs3_tx #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  ser_out,
    output logic                  ser_frame,
    output logic                  done,
    output logic                  err
);

    localparam int W = 4 * DIGITS;
`ifdef CYQ_XS3_TX_PARITY_EN
    localparam int FRAME_LEN = W + 1;
`else
    localparam int FRAME_LEN = W;
`endif
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [FRAME_LEN-1:0] sreg, sreg_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic                 err_q, err_nxt;
    logic                 ready_q;
    logic [W-1:0]         enc;
    logic                 bad;
    logic [FRAME_LEN-1:0] frame_word;

    // NOTE: every variable written in an always_comb gets a value before any branch, so no latch is inferred.
    always_comb begin : encode
        enc = '0;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (din[4*k +: 4] > 4'd9) bad = 1'b1;
            enc[4*k +: 4] = din[4*k +: 4] + 4'd3;
        end
    end

`ifdef CYQ_XS3_TX_PARITY_EN
    // Odd parity: the parity bit makes the total count of ones in the frame odd.
    assign frame_word = {enc, ~^enc};
`else
    assign frame_word = enc;
`endif

    always_comb begin : next_state
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (ready_q && din_valid) begin
                    if (bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        sreg_nxt  = frame_word;
                        cnt_nxt   = CNT_LAST;
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Zeros shift in behind the frame, so sreg is empty again by DONE.
                sreg_nxt = {sreg[FRAME_LEN-2:0], 1'b0};
                if (cnt == '0) begin
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            cnt     <= cnt_nxt;
            err_q   <= err_nxt;
            ready_q <= (state_nxt == IDLE);
        end
    end

    assign din_ready = ready_q;
    assign ser_out   = sreg[FRAME_LEN-1];
    assign ser_frame = (state == SHIFT);
    assign done      = (state == DONE);
    assign err       = err_q;

endmodule
